// File: rtl/conv_pkg.sv
// Shared types for the 5x5 window generator and the conv datapath behind it.
package conv_pkg;
  localparam int KERNEL   = 5;
  localparam int PIX_W    = 8;
  localparam int CONV_LAT = 5;

  typedef logic signed [PIX_W-1:0] pix_t;
  typedef pix_t window_t [KERNEL-1:0][KERNEL-1:0];
endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage. The read port is registered and is fed the
// address of the *next* column to be accepted, so rdata_o always holds the
// pre-write contents of the column currently being accepted.
module line_buffer
  import conv_pkg::pix_t;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  pix_t          wdata_i,
  input  logic [AW-1:0] raddr_i,
  output pix_t          rdata_o
);

  pix_t mem [DEPTH];

  // Write on accept; read every cycle (old data on address collision).
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 5x5 "valid"-mode window generator with a valid/last delay line
// matching the latency of the downstream conv datapath.
module conv_window_gen
  import conv_pkg::pix_t;
  import conv_pkg::window_t;
#(
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int KERNEL   = 5,
  parameter int PIX_W    = 8,
  parameter int CONV_LAT = 5,
  localparam int XW = (IMG_W - 4 > 1) ? $clog2(IMG_W - 4) : 1,
  localparam int YW = (IMG_H - 4 > 1) ? $clog2(IMG_H - 4) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  pix_t          in_pixel,
  output window_t       window,
  output logic          win_valid,
  output logic          win_last,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          res_valid,
  output logic          res_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_K    = CW'(KERNEL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_K    = RW'(KERNEL - 1);

  if (KERNEL != 5) begin : g_bad_kernel
    $error("conv_window_gen: KERNEL must be 5 to match the conv datapath");
  end
  if (PIX_W != $bits(pix_t)) begin : g_bad_pixw
    $error("conv_window_gen: PIX_W must match conv_pkg::pix_t");
  end
  if (IMG_W < KERNEL || IMG_H < KERNEL) begin : g_bad_img
    $error("conv_window_gen: image must be at least KERNEL x KERNEL");
  end
  if (CONV_LAT < 1) begin : g_bad_lat
    $error("conv_window_gen: CONV_LAT must be >= 1");
  end

  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  window_t             win_q;
  logic                win_valid_q, win_last_q;
  logic [XW-1:0]       out_x_q;
  logic [YW-1:0]       out_y_q;
  logic [CONV_LAT-1:0] vld_pipe_q, lst_pipe_q;
  pix_t                lb_rd [KERNEL-1];
  pix_t                lb_wr [KERNEL-1];

  // Next pixel coordinates; forced to (0,0) in reset so the line buffers
  // prefetch column 0 for the first beat of the fresh frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (!rst_n) begin
      col_d = '0;
      row_d = '0;
    end else if (in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Four chained rows: each buffer takes the next-younger row's old value,
  // the youngest takes the incoming pixel.
  for (genvar k = 0; k < KERNEL - 1; k++) begin : g_lb
    if (k == KERNEL - 2) begin : g_top
      assign lb_wr[k] = in_pixel;
    end else begin : g_chain
      assign lb_wr[k] = lb_rd[k+1];
    end
    line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb (
      .clk     (clk),
      .we_i    (in_valid & rst_n),
      .waddr_i (col_q),
      .wdata_i (lb_wr[k]),
      .raddr_i (col_d),
      .rdata_o (lb_rd[k])
    );
  end

  // Counters, 5x5 shift window and the window valid/last/coordinate tags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      for (int i = 0; i < KERNEL; i++)
        for (int j = 0; j < KERNEL; j++)
          win_q[i][j] <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      // col>=4 also suppresses windows straddling a row wrap.
      win_valid_q <= in_valid && (row_q >= ROW_K) && (col_q >= COL_K);
      win_last_q  <= in_valid && (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (in_valid) begin
        out_x_q <= XW'(col_q - COL_K);
        out_y_q <= YW'(row_q - ROW_K);
        for (int i = 0; i < KERNEL; i++)
          for (int j = 0; j < KERNEL - 1; j++)
            win_q[i][j] <= win_q[i][j+1];
        for (int i = 0; i < KERNEL - 1; i++)
          win_q[i][KERNEL-1] <= lb_rd[i];
        win_q[KERNEL-1][KERNEL-1] <= in_pixel;
      end
    end
  end

  // Valid/last delay line; free-running because the conv never stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      lst_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= win_valid_q;
      lst_pipe_q[0] <= win_last_q;
      for (int s = 1; s < CONV_LAT; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        lst_pipe_q[s] <= lst_pipe_q[s-1];
      end
    end
  end

  assign window    = win_q;
  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign res_valid = vld_pipe_q[CONV_LAT-1];
  assign res_last  = lst_pipe_q[CONV_LAT-1];

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: an 8x8 instance and a 12x6 instance, each with a
// frame-image reference model and a per-cycle output compare.
module tb_conv_window_gen;
  import conv_pkg::*;

  logic clk;
  logic rst_n    [2];
  logic in_valid [2];
  pix_t in_pixel [2];

  int n_pass = 0;
  int n_tot  = 0;

  int win_cnt [2], last_cnt [2], res_cnt [2], reslast_cnt [2];
  int last_x [2], last_y [2];
  bit got_first [2], got_conv [2];
  int fw00 [2], fw04 [2], fw40 [2], fw44 [2], fx [2], fy [2], first_acc [2];
  int conv_first [2], conv_last [2], conv_last_flag [2];
  int w00_q [2][$];
  int xs [2][$];
  int ys [2][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int W  = (g == 0) ? 8 : 12;
    localparam int H  = (g == 0) ? 8 : 6;
    localparam int XW = (W - 4 > 1) ? $clog2(W - 4) : 1;
    localparam int YW = (H - 4 > 1) ? $clog2(H - 4) : 1;

    window_t       win;
    logic          wv, wl, rv, rl;
    logic [XW-1:0] ox;
    logic [YW-1:0] oy;

    conv_window_gen #(.IMG_W(W), .IMG_H(H), .KERNEL(5), .PIX_W(8), .CONV_LAT(5)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .in_valid  (in_valid[g]),
      .in_pixel  (in_pixel[g]),
      .window    (win),
      .win_valid (wv),
      .win_last  (wl),
      .out_x     (ox),
      .out_y     (oy),
      .res_valid (rv),
      .res_last  (rl)
    );

    // Reference: store the frame as an image, cut the 5x5 neighbourhood out
    // of it for each in-frame position, delay the tags through a plain array.
    int   n = 0, acc = 0;
    pix_t img [H][W];
    bit   e_v, e_l, e_rv, e_rl;
    int   e_x, e_y;
    pix_t e_win [5][5];
    bit   dl_v [5];
    bit   dl_l [5];
    int   sums [6];

    always @(posedge clk) begin : model
      int c, r;
      if (!rst_n[g]) begin
        n = 0; acc = 0;
        e_v = 0; e_l = 0; e_rv = 0; e_rl = 0; e_x = 0; e_y = 0;
        for (int k = 0; k < 5; k++) begin dl_v[k] = 0; dl_l[k] = 0; end
      end else begin
        for (int k = 4; k > 0; k--) begin dl_v[k] = dl_v[k-1]; dl_l[k] = dl_l[k-1]; end
        dl_v[0] = e_v; dl_l[0] = e_l;
        e_rv = dl_v[4]; e_rl = dl_l[4];
        e_v = 0; e_l = 0;
        if (in_valid[g]) begin
          c = n % W; r = n / W;
          img[r][c] = in_pixel[g];
          acc++;
          if (r >= 4 && c >= 4) begin
            e_v = 1; e_l = (n == W * H - 1);
            e_x = c - 4; e_y = r - 4;
            for (int i = 0; i < 5; i++)
              for (int j = 0; j < 5; j++)
                e_win[i][j] = img[r-4+i][c-4+j];
          end
          n = (n + 1) % (W * H);
        end
      end
    end

    always @(negedge clk) begin : cmp
      logic [39:0] gr, er;
      int s;
      chk($sformatf("d%0d_win_valid", g), wv, e_v);
      chk($sformatf("d%0d_win_last", g), wl, e_l);
      chk($sformatf("d%0d_res_valid", g), rv, e_rv);
      chk($sformatf("d%0d_res_last", g), rl, e_rl);
      if (e_v) begin
        chk($sformatf("d%0d_out_x", g), ox, e_x);
        chk($sformatf("d%0d_out_y", g), oy, e_y);
        for (int i = 0; i < 5; i++) begin
          gr = '0; er = '0;
          for (int j = 0; j < 5; j++) begin
            gr = {gr[31:0], win[i][j]};
            er = {er[31:0], e_win[i][j]};
          end
          chk($sformatf("d%0d_win_row%0d", g, i), longint'(gr), longint'(er));
        end
      end
      // Stand-in for the conv with all weights 1: sum, delayed 5 cycles.
      s = 0;
      if (wv) for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) s += int'(win[i][j]);
      for (int k = 5; k > 0; k--) sums[k] = sums[k-1];
      sums[0] = s;
      if (wv) begin
        win_cnt[g]++;
        w00_q[g].push_back(int'(win[0][0]));
        xs[g].push_back(int'(ox));
        ys[g].push_back(int'(oy));
        if (wl) begin last_cnt[g]++; last_x[g] = int'(ox); last_y[g] = int'(oy); end
        if (!got_first[g]) begin
          got_first[g] = 1;
          fw00[g] = int'(win[0][0]); fw04[g] = int'(win[0][4]);
          fw40[g] = int'(win[4][0]); fw44[g] = int'(win[4][4]);
          fx[g] = int'(ox); fy[g] = int'(oy); first_acc[g] = acc;
        end
      end
      if (rv) begin
        res_cnt[g]++;
        if (!got_conv[g]) begin got_conv[g] = 1; conv_first[g] = sums[5]; end
        conv_last[g] = sums[5];
        conv_last_flag[g] = int'(rl);
        if (rl) reslast_cnt[g]++;
      end
    end
  end

  task automatic clear(input int g);
    win_cnt[g] = 0; last_cnt[g] = 0; res_cnt[g] = 0; reslast_cnt[g] = 0;
    last_x[g] = -1; last_y[g] = -1; got_first[g] = 0; got_conv[g] = 0;
    fw00[g] = -1; fw04[g] = -1; fw40[g] = -1; fw44[g] = -1; fx[g] = -1; fy[g] = -1;
    first_acc[g] = -1; conv_first[g] = -1; conv_last[g] = -1; conv_last_flag[g] = 0;
    w00_q[g].delete(); xs[g].delete(); ys[g].delete();
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // cnt ramp pixels base+n; random idle gaps (at most 5 in a row) when gap_pct>0.
  task automatic send(input int g, input int cnt, input int base, input int gap_pct);
    for (int n = 0; n < cnt; n++) begin
      int gaps = 0;
      while (gap_pct > 0 && gaps < 5 && int'($urandom_range(99, 0)) < gap_pct) begin
        @(posedge clk); #1;
        gaps++;
      end
      in_valid[g] = 1'b1;
      in_pixel[g] = pix_t'(base + n);
      @(posedge clk); #1;
      in_valid[g] = 1'b0;
    end
  endtask

  task automatic rst_pulse(input int g);
    rst_n[g] = 1'b0;
    @(posedge clk); #1;
    rst_n[g] = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b0; in_valid[g] = 1'b0; in_pixel[g] = '0; clear(g);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // Gapless ramp frame.
    clear(0); send(0, 64, 0, 0); idle(10);
    chk("s1_nwin", win_cnt[0], 16);
    chk("s1_first_acc", first_acc[0], 37);
    chk("s1_w00", fw00[0], 0);
    chk("s1_w04", fw04[0], 4);
    chk("s1_w40", fw40[0], 32);
    chk("s1_w44", fw44[0], 36);
    chk("s1_x0", fx[0], 0);
    chk("s1_y0", fy[0], 0);
    chk("s1_nlast", last_cnt[0], 1);
    chk("s1_last_x", last_x[0], 3);
    chk("s1_last_y", last_y[0], 3);
    chk("s1_nres", res_cnt[0], 16);
    chk("s1_conv_first", conv_first[0], 450);
    chk("s1_conv_last", conv_last[0], 1125);
    chk("s1_conv_last_tag", conv_last_flag[0], 1);
    chk("s1_nres_last", reslast_cnt[0], 1);

    // Same frame with ~40% idle gaps.
    clear(0); send(0, 64, 0, 40); idle(10);
    chk("s2_nwin", win_cnt[0], 16);
    chk("s2_w44", fw44[0], 36);
    chk("s2_conv_first", conv_first[0], 450);
    chk("s2_conv_last", conv_last[0], 1125);

    // Two frames back to back, second offset by 64.
    clear(0); send(0, 64, 0, 0); send(0, 64, 64, 0); idle(10);
    chk("s3_nwin", w00_q[0].size(), 32);
    chk("s3_f1_w00", (w00_q[0].size() > 0) ? w00_q[0][0] : -1, 0);
    chk("s3_f2_w00", (w00_q[0].size() > 16) ? w00_q[0][16] : -1, 64);
    chk("s3_nlast", last_cnt[0], 2);

    // Reset after pixel 20, then a full frame.
    send(0, 21, 0, 0); rst_pulse(0); clear(0);
    send(0, 64, 0, 0); idle(10);
    chk("s4_first_acc", first_acc[0], 37);
    chk("s4_nwin", win_cnt[0], 16);
    chk("s4_conv_first", conv_first[0], 450);
    chk("s4_nres", res_cnt[0], 16);

    // Reset with results still in the delay line: none may emerge.
    send(0, 46, 0, 0); rst_pulse(0);
    chk("s5_rst_w00", int'(g_dut[0].win[0][0]), 0);
    chk("s5_rst_w44", int'(g_dut[0].win[4][4]), 0);
    chk("s5_rst_x", int'(g_dut[0].ox), 0);
    chk("s5_rst_y", int'(g_dut[0].oy), 0);
    clear(0); idle(10);
    chk("s5_nres_flush", res_cnt[0], 0);
    chk("s5_nwin_flush", win_cnt[0], 0);
    send(0, 64, 0, 20); idle(10);
    chk("s5_nwin", win_cnt[0], 16);
    chk("s5_w44", fw44[0], 36);

    // 12x6 ramp on the second instance.
    clear(1); send(1, 72, 0, 0); idle(10);
    chk("s6_nwin", win_cnt[1], 16);
    chk("s6_first_acc", first_acc[1], 53);
    chk("s6_w44", fw44[1], 52);
    chk("s6_w00", fw00[1], 0);
    chk("s6_x7", (xs[1].size() > 8) ? xs[1][7] : -1, 7);
    chk("s6_y7", (ys[1].size() > 8) ? ys[1][7] : -1, 0);
    chk("s6_x8", (xs[1].size() > 8) ? xs[1][8] : -1, 0);
    chk("s6_y8", (ys[1].size() > 8) ? ys[1][8] : -1, 1);
    chk("s6_nres", res_cnt[1], 16);
    chk("s6_last_x", last_x[1], 7);
    chk("s6_last_y", last_y[1], 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
